// File: rtl/wptr_full_param.sv
// Purpose : write-side pointer/status for an async FIFO of depth 2**ASIZE, wclk domain only.
// Latency : wen is combinational; wptr/wfull/walmost_full/wfree/wovf register on the accepting edge.
// Backpres: winc is refused (wen=0) while wfull; a refused write sets sticky wovf.
//
// Ports:
//   wclk, wrst_n      write clock, async active-low reset
//   winc              producer write request
//   wq2_rptr          read Gray pointer, already synchronised into wclk
//   wovf_clr          clears sticky overflow
//   waddr, wen        memory write address / enable
//   wptr              Gray write pointer towards the read-side synchroniser
//   wfull, walmost_full, wfree, wovf   registered status
module wptr_full_param #(
  parameter int ASIZE        = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             wovf_clr,
  output logic [ASIZE-1:0] waddr,
  output logic             wen,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wfree,
  output logic             wovf
);

  localparam int DEPTH = 1 << ASIZE;

  // Parameter legality is checked at elaboration; the full compare below
  // also needs at least two address bits.
  generate
    if (ASIZE < 2) begin : g_bad_asize
      $error("wptr_full_param: ASIZE must be >= 2");
    end
    if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
      $error("wptr_full_param: AFULL_MARGIN must be in 1..DEPTH-1");
    end
  endgenerate

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbinnext;
  logic [ASIZE:0] wgraynext;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] fill_next;
  logic [ASIZE:0] free_next;
  logic           full_next;
  logic           afull_next;

  assign wen       = winc & ~wfull;
  assign waddr     = wbin[ASIZE-1:0];
  assign wbinnext  = wbin + {{ASIZE{1'b0}}, wen};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Fill is computed against the post-write pointer so the status flags
  // move on the same edge that accepts the write. A stale (synchronised)
  // read pointer can only overstate fill, so free space is never overstated.
  assign fill_next  = wbinnext - rbin;
  assign free_next  = (ASIZE+1)'(DEPTH) - fill_next;
  assign afull_next = (free_next <= (ASIZE+1)'(AFULL_MARGIN));

  // Full when the pointers differ only in their two MSBs (Gray form of
  // "same address, opposite wrap").
  assign full_next  = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wfree        <= (ASIZE+1)'(DEPTH);
      wovf         <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wfree        <= free_next;
      // A refused write takes priority over a clear in the same cycle.
      if (winc && wfull) begin
        wovf <= 1'b1;
      end else if (wovf_clr) begin
        wovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full_param.sv
// Purpose : directed check of wptr_full_param (ASIZE=4, AFULL_MARGIN=2).
// Latency : inputs driven 1 time unit after posedge; outputs sampled there too.
// Backpres: n/a (bench).
module tb_wptr_full_param;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b1;
  logic       winc = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic       wovf_clr = 1'b0;
  logic [3:0] waddr;
  logic       wen;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wfree;
  logic       wovf;

  int vectors = 0;
  int fails   = 0;

  wptr_full_param #(.ASIZE(4), .AFULL_MARGIN(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .wovf_clr(wovf_clr), .waddr(waddr), .wen(wen), .wptr(wptr),
    .wfull(wfull), .walmost_full(walmost_full), .wfree(wfree), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_wptr"},  32'(wptr),  32'd0);
    chk({tag, "_wfull"}, 32'(wfull), 32'd0);
    chk({tag, "_wafull"}, 32'(walmost_full), 32'd0);
    chk({tag, "_wfree"}, 32'(wfree), 32'd16);
    chk({tag, "_wovf"},  32'(wovf),  32'd0);
  endtask

  initial begin
    logic [4:0] h1, h2, prev, exp_bin, rexp;
    logic [3:0] prev_addr;
    int addr_wraps, bin_wraps;

    // 1. asynchronous reset
    #1 wrst_n = 1'b0;
    #1 chk_reset_vals("rst");
    #6 wrst_n = 1'b1;

    // 2. fill from empty with read pointer at 0
    wq2_rptr = 5'b00000;
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 13) begin
        chk("fill13_wfree", 32'(wfree), 32'd3);
        chk("fill13_wafull", 32'(walmost_full), 32'd0);
      end
      if (i == 14) begin
        chk("fill14_wfree", 32'(wfree), 32'd2);
        chk("fill14_wafull", 32'(walmost_full), 32'd1);
      end
      if (i == 15) chk("fill15_wfull", 32'(wfull), 32'd0);
    end
    chk("full_wfull", 32'(wfull), 32'd1);
    chk("full_wfree", 32'(wfree), 32'd0);
    chk("full_wptr",  32'(wptr),  32'b11000);
    chk("full_waddr", 32'(waddr), 32'd0);
    chk("full_wafull", 32'(walmost_full), 32'd1);

    // 3. writes while full -> overflow, clear priority
    chk("ovf_wen", 32'(wen), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovf_wptr", 32'(wptr), 32'b11000);
      chk("ovf_wovf", 32'(wovf), 32'd1);
      chk("ovf_waddr", 32'(waddr), 32'd0);
    end
    wovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(wovf), 32'd1);
    winc = 1'b0;
    tick();
    chk("ovf_clr", 32'(wovf), 32'd0);
    wovf_clr = 1'b0;

    // 4. read side advances to 3 -> full releases, then one write
    wq2_rptr = 5'b00010;
    tick();
    chk("rel_wfull", 32'(wfull), 32'd0);
    chk("rel_wfree", 32'(wfree), 32'd3);
    chk("rel_wafull", 32'(walmost_full), 32'd0);
    winc = 1'b1;
    tick();
    winc = 1'b0;
    chk("rel_w_wfree", 32'(wfree), 32'd2);
    chk("rel_w_wafull", 32'(walmost_full), 32'd1);
    chk("rel_w_wptr", 32'(wptr), 32'b11001);

    // 5. streaming with read pointer two cycles behind
    exp_bin = 5'd17;
    h1 = wptr;
    h2 = wptr;
    addr_wraps = 0;
    bin_wraps = 0;
    winc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wq2_rptr = h2;
      h2 = h1;
      h1 = wptr;
      #1;
      chk("strm_wen", 32'(wen), 32'd1);
      prev = wptr;
      prev_addr = waddr;
      tick();
      exp_bin = exp_bin + 5'd1;
      rexp = 5'(exp_bin - g2b(wq2_rptr));
      chk("strm_wfull", 32'(wfull), 32'd0);
      chk("strm_wptr", 32'(wptr), 32'(gray(exp_bin)));
      chk("strm_onebit", 32'($countones(prev ^ wptr)), 32'd1);
      chk("strm_wfree", 32'(wfree), 32'd16 - 32'(rexp));
      if (prev_addr == 4'd15 && waddr == 4'd0) addr_wraps++;
      if (prev == 5'b10000 && wptr == 5'b00000) bin_wraps++;
    end
    winc = 1'b0;
    chk("strm_addr_wraps", 32'(addr_wraps), 32'd2);
    chk("strm_bin_wraps", 32'(bin_wraps), 32'd1);

    // 6. reset pulse between edges mid-operation
    wrst_n = 1'b0;
    #1 wrst_n = 1'b1;
    wq2_rptr = 5'b00000;
    winc = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    winc = 1'b0;
    chk("pre_rst_waddr", 32'(waddr), 32'd9);
    wrst_n = 1'b0;
    #2 chk_reset_vals("mid_rst");
    #2 wrst_n = 1'b1;
    winc = 1'b1;
    #1;
    chk("post_rst_waddr", 32'(waddr), 32'd0);
    chk("post_rst_wen", 32'(wen), 32'd1);
    tick();
    winc = 1'b0;
    chk("post_rst_wptr", 32'(wptr), 32'b00001);
    chk("post_rst_waddr1", 32'(waddr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/wptr_full_param.md
Name: wptr_full_param

Overview:
Parametrised write-side pointer and status block for the asynchronous FIFO. It generalises the fixed 16-entry write-pointer/full logic to any power-of-two depth, and runs entirely in the write clock domain. It consumes the read pointer already synchronised into this domain. It produces the binary memory write address, the Gray write pointer for the read-side synchroniser, the memory write enable, and full, almost-full, free-count and sticky overflow status.

Parameters:
ASIZE, 4, address width; DEPTH = 2**ASIZE entries; pointers are ASIZE+1 bits.
AFULL_MARGIN, 2, walmost_full asserts when free slots <= AFULL_MARGIN; legal range 1..DEPTH-1, elaboration error otherwise.

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
winc  in  1  write request from producer
wq2_rptr  in  ASIZE+1  read Gray pointer, already 2-flop synchronised to wclk
wovf_clr  in  1  clears sticky overflow flag
waddr  out  ASIZE  binary write address = wbin[ASIZE-1:0]
wen  out  1  memory write enable = winc & ~wfull (combinational)
wptr  out  ASIZE+1  registered Gray write pointer
wfull  out  1  registered full flag
walmost_full  out  1  registered almost-full flag
wfree  out  ASIZE+1  registered free-slot count, 0..DEPTH
wovf  out  1  sticky overflow: write attempted while full

Behaviour:
- Clock/reset: single clock wclk; reset wrst_n is asynchronous, active-low. All state clears immediately on assertion, independent of wclk. Reset values: wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wfree=DEPTH, wovf=0.
- Binary state wbin, ASIZE+1 bits. wbinnext = wbin + wen, modulo 2**(ASIZE+1). wgraynext = (wbinnext>>1) ^ wbinnext.
- Each wclk edge: wbin<=wbinnext; wptr<=wgraynext. wptr is always the Gray code of wbin; consecutive values differ in exactly one bit.
- Full: wfull <= (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}). The flag asserts on the same edge that accepts the filling write, with no extra latency.
- Read pointer decode: rbin = Gray-to-binary of wq2_rptr, combinational prefix-XOR from the MSB.
- Fill: fill_next = wbinnext - rbin, modulo 2**(ASIZE+1), range 0..DEPTH.
- Registered status: wfree <= DEPTH - fill_next. walmost_full <= (DEPTH - fill_next) <= AFULL_MARGIN. wfull, walmost_full and wfree update on the same edge and are always mutually consistent: wfull implies walmost_full, and wfull holds exactly when wfree==0.
- Write while full: winc=1 and wfull=1 gives wen=0. wbin, waddr and wptr hold. wovf <= 1 on that edge.
- Overflow clear: wovf_clr=1 clears wovf next edge. If the set condition and wovf_clr occur in the same cycle, set wins.
- Full release: pessimistic only. Full deasserts one wclk after wq2_rptr advances. The block never reports more free space than exists.
- Wrap: wbin wraps 2**(ASIZE+1)-1 -> 0. waddr wraps DEPTH-1 -> 0. The MSB toggle distinguishes full from empty.
- Simultaneous write accept and read-pointer advance in one cycle: fill_next reflects both, so fill is unchanged and wfree is unchanged.
- Reset mid-operation: outputs take reset values asynchronously. The first accepted write after release uses waddr=0.

Test Plan:
1. Reset with ASIZE=4, AFULL_MARGIN=2 -> waddr=0, wptr=5'b00000, wfull=0, walmost_full=0, wfree=16, wovf=0.
2. wq2_rptr=0, winc=1 for 16 cycles -> after 14th edge walmost_full=1, wfree=2. After 16th edge wfull=1, wfree=0, wptr=5'b11000, waddr=0.
3. While full, winc=1 for 3 cycles -> wen=0, wptr stays 5'b11000, wovf=1 next edge. Then wovf_clr and winc both 1 -> wovf stays 1. wovf_clr alone -> wovf=0.
4. From full, set wq2_rptr=gray(3)=5'b00010 -> next edge wfull=0, wfree=3, walmost_full=0 (3>2). One write -> wfree=2, walmost_full=1.
5. Continuous winc for 40 cycles with wq2_rptr tracking wptr two cycles late -> wfull never asserts. waddr wraps 15->0 twice. Every wptr change flips exactly one bit; wbin wraps 31->0.
6. Pulse wrst_n low between edges after 9 writes -> all outputs at reset values immediately without a wclk edge. Next accepted write has waddr=0 and wptr becomes 5'b00001.
